fx3_gpif_reader: RTL

- Synthesizable FX3-side counterpart of the FPGA sample-streaming interface, used on a bring-up/loopback board in place of the FX3.
- Drives collectData/readData and waits for dataAvailable.
- Reads fixed-length bursts from the 16-bit databus and presents captured words on a valid strobe.
- Keeps word/burst counters and a sticky buffer-error flag; optionally checks the test-mode data pattern.

---
 rtl/fx3_gpif_reader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fx3_gpif_reader.sv
// fx3_gpif_reader: FX3-side GPIF burst reader used in place of the FX3 on the loopback board.
// Define TEST_PATTERN_CHECK_EN to build the test-mode data pattern checker.
module fx3_gpif_reader #(
    parameter int BURST_WORDS  = 8192,
    parameter int READ_LATENCY = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic        inclk,
    input  logic        nReset,
    input  logic        enable,
    input  logic        dataAvailable,
    input  logic        bufferError,
    input  logic [15:0] databus,
    output logic        collectData,
    output logic        readData,
    output logic        wordValid,
    output logic [15:0] wordOut,
    output logic [31:0] wordCount,
    output logic [15:0] burstCount,
    output logic        burstDone,
    output logic        bufferErrorSeen,
    output logic [15:0] patternErrors
);

    localparam int WORD_W = $clog2(BURST_WORDS + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(BURST_WORDS - 1);
    localparam logic [WORD_W-1:0] DROP_IDX = WORD_W'(BURST_WORDS - READ_LATENCY - 1);
    localparam logic [2:0]        LAT_LAST = 3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_AVAIL,
        LATENCY,
        BURST,
        GAP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        lat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] word_idx;
    logic              capture;
    logic              last_word;
    logic              raise_read;
    logic              drop_read;
    logic              read_next;

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // With a latency of one the first word is due straight after the request edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (collectData) begin
                    next_state = WAIT_AVAIL;
                end
            end
            WAIT_AVAIL: begin
                if (!collectData) begin
                    next_state = IDLE;
                end else if (dataAvailable) begin
                    next_state = (READ_LATENCY == 1) ? BURST : LATENCY;
                end
            end
            LATENCY: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                if (last_word) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    next_state = collectData ? WAIT_AVAIL : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture    = (state == BURST);
        last_word  = capture && (word_idx == LAST_IDX);
        raise_read = (state == WAIT_AVAIL) && collectData && dataAvailable;
        drop_read  = capture && (word_idx == DROP_IDX);
        read_next  = readData;
        if (raise_read) begin
            read_next = 1'b1;
        end
        if (drop_read || (state == IDLE) || (state == GAP)) begin
            read_next = 1'b0;
        end
    end

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            lat_cnt  <= '0;
            gap_cnt  <= '0;
            word_idx <= '0;
        end else begin
            lat_cnt  <= (state == LATENCY) ? lat_cnt + 3'd1 : 3'd0;
            gap_cnt  <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            word_idx <= capture ? word_idx + WORD_W'(1) : '0;
        end
    end

    // Buffer errors are only recorded, never used to cut a burst short.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            collectData     <= 1'b0;
            readData        <= 1'b0;
            wordValid       <= 1'b0;
            wordOut         <= '0;
            wordCount       <= '0;
            burstCount      <= '0;
            burstDone       <= 1'b0;
            bufferErrorSeen <= 1'b0;
        end else begin
            collectData <= enable;
            readData    <= read_next;
            wordValid   <= capture;
            burstDone   <= last_word;
            if (capture) begin
                wordOut   <= databus;
                wordCount <= wordCount + 32'd1;
            end
            if (last_word) begin
                burstCount <= burstCount + 16'd1;
            end
            if (bufferError && collectData) begin
                bufferErrorSeen <= 1'b1;
            end
        end
    end

`ifdef TEST_PATTERN_CHECK_EN
    logic       seeded;
    logic [9:0] expect_low;
    logic       pattern_miss;

    assign pattern_miss = seeded && (databus != {6'b0, expect_low});

    // A new run re-seeds from its first word; a word captured on that same edge is ignored.
    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            seeded        <= 1'b0;
            expect_low    <= '0;
            patternErrors <= '0;
        end else if (enable && !collectData) begin
            seeded <= 1'b0;
        end else if (capture) begin
            seeded     <= 1'b1;
            expect_low <= databus[9:0] + 10'd1;
            if (pattern_miss && (patternErrors != 16'hFFFF)) begin
                patternErrors <= patternErrors + 16'd1;
            end
        end
    end
`else
    assign patternErrors = '0;
`endif

endmodule
